// File: rtl/umi_pkg.sv
// ----------------------------------------------------------------------------
// umi_pkg
// Shared UMI definitions for the SUMI fabric blocks.
//   UMI_EOM_BIT : position of the end-of-message flag inside the command word
//   UMI_*W      : default UMI field widths
//   umi_req_t   : one UMI request word {cmd, dstaddr, srcaddr, data}
// ----------------------------------------------------------------------------
package umi_pkg;

    localparam int UMI_EOM_BIT = 22;
    localparam int UMI_CW      = 32;
    localparam int UMI_AW      = 64;
    localparam int UMI_DW      = 256;

    typedef struct packed {
        logic [UMI_CW-1:0] cmd;
        logic [UMI_AW-1:0] dstaddr;
        logic [UMI_AW-1:0] srcaddr;
        logic [UMI_DW-1:0] data;
    } umi_req_t;

endpackage

// File: rtl/umi_demux_fifo.sv
// ----------------------------------------------------------------------------
// umi_demux_fifo
// Single-channel DEPTH x W register FIFO used once per demux output.
//   clk, nreset : clock, asynchronous active-low reset (pointers only)
//   push_i/din_i: write request and word; ignored while full_o
//   full_o      : no free slot
//   pop_i       : consume head entry; ignored while empty_o
//   empty_o     : no stored word
//   dout_o      : head entry, stable until popped
// ----------------------------------------------------------------------------
module umi_demux_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    input  logic         pop_i,
    output logic         empty_o,
    output logic [W-1:0] dout_o
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]  wrPtr_q, wrPtr_d;
    logic [PW:0]  rdPtr_q, rdPtr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         doPush;
    logic         doPop;

    assign full_o  = (wrPtr_q[PW] != rdPtr_q[PW]) && (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign dout_o  = mem_q[rdPtr_q[PW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage is deliberately not reset; valid is governed by the pointers.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/umi_demux_buf.sv
// ----------------------------------------------------------------------------
// umi_demux_buf
// Buffered, transaction-aware 1-to-M UMI demultiplexer. The output channel is
// decoded from dstaddr[SEL_LSB +: SW]; multi-word transactions stay locked to
// the channel of their first word until the EOM word. Each output has its own
// FIFO so a stalled output never blocks the others.
//   clk, nreset          : clock, asynchronous active-low reset
//   umi_in_*             : host-side UMI request (valid/ready handshake)
//   umi_out_valid/ready  : per-channel handshake, M bits
//   umi_out_cmd/dstaddr/srcaddr/data : packed per-channel fields, slice i*W +: W
//   drop_err             : sticky, a word decoded to a channel index >= M
//   busy                 : some FIFO holds data or a transaction lock is open
// ----------------------------------------------------------------------------
module umi_demux_buf
    import umi_pkg::*;
#(
    parameter int M       = 4,
    parameter int DW      = 256,
    parameter int CW      = 32,
    parameter int AW      = 64,
    parameter int SEL_LSB = 40,
    parameter int DEPTH   = 2
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            umi_in_valid,
    input  logic [CW-1:0]   umi_in_cmd,
    input  logic [AW-1:0]   umi_in_dstaddr,
    input  logic [AW-1:0]   umi_in_srcaddr,
    input  logic [DW-1:0]   umi_in_data,
    output logic            umi_in_ready,
    output logic [M-1:0]    umi_out_valid,
    output logic [M*CW-1:0] umi_out_cmd,
    output logic [M*AW-1:0] umi_out_dstaddr,
    output logic [M*AW-1:0] umi_out_srcaddr,
    output logic [M*DW-1:0] umi_out_data,
    input  logic [M-1:0]    umi_out_ready,
    output logic            drop_err,
    output logic            busy
);

    localparam int SW = $clog2(M);
    localparam int FW = CW + 2*AW + DW;
    localparam logic [SW:0] NUM_CH = (SW+1)'(M);

    logic [SW-1:0] decIdx;
    logic [SW-1:0] target;
    logic          outOfRange;
    logic          eom;
    logic          accept;
    logic          targetFull;
    logic [M-1:0]  targetHit;
    logic [M-1:0]  pushVec;
    logic [M-1:0]  fullVec;
    logic [M-1:0]  emptyVec;
    logic [FW-1:0] inWord;
    logic [FW-1:0] headWord [M];

    logic          lockVld_q, lockVld_d;
    logic [SW-1:0] lockIdx_q, lockIdx_d;
    logic          dropErr_q, dropErr_d;

    assign decIdx     = umi_in_dstaddr[SEL_LSB +: SW];
    assign target     = lockVld_q ? lockIdx_q : decIdx;
    // A held lock always points at a real channel, so only unlocked words drop.
    assign outOfRange = !lockVld_q && ({1'b0, decIdx} >= NUM_CH);
    assign eom        = umi_in_cmd[UMI_EOM_BIT];
    assign inWord     = {umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data};

    // Ready looks only at the target FIFO's full flag; never at umi_out_ready.
    always_comb begin
        targetFull = 1'b0;
        targetHit  = '0;
        for (int i = 0; i < M; i++) begin
            if (target == SW'(i)) begin
                targetFull   = fullVec[i];
                targetHit[i] = 1'b1;
            end
        end
    end

    assign umi_in_ready = outOfRange || !targetFull;
    assign accept       = umi_in_valid && umi_in_ready;
    assign pushVec      = targetHit & {M{accept && !outOfRange}};

    always_comb begin
        lockVld_d = lockVld_q;
        lockIdx_d = lockIdx_q;
        dropErr_d = dropErr_q;
        if (accept) begin
            if (outOfRange) begin
                dropErr_d = 1'b1;
            end else if (eom) begin
                lockVld_d = 1'b0;
            end else if (!lockVld_q) begin
                lockVld_d = 1'b1;
                lockIdx_d = target;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lockVld_q <= 1'b0;
            lockIdx_q <= '0;
            dropErr_q <= 1'b0;
        end else begin
            lockVld_q <= lockVld_d;
            lockIdx_q <= lockIdx_d;
            dropErr_q <= dropErr_d;
        end
    end

    for (genvar g = 0; g < M; g++) begin : gChan
        umi_demux_fifo #(
            .W     (FW),
            .DEPTH (DEPTH)
        ) uFifo (
            .clk     (clk),
            .nreset  (nreset),
            .push_i  (pushVec[g]),
            .din_i   (inWord),
            .full_o  (fullVec[g]),
            .pop_i   (umi_out_ready[g]),
            .empty_o (emptyVec[g]),
            .dout_o  (headWord[g])
        );

        assign umi_out_valid[g]               = !emptyVec[g];
        assign umi_out_data[g*DW +: DW]       = headWord[g][0 +: DW];
        assign umi_out_srcaddr[g*AW +: AW]    = headWord[g][DW +: AW];
        assign umi_out_dstaddr[g*AW +: AW]    = headWord[g][DW+AW +: AW];
        assign umi_out_cmd[g*CW +: CW]        = headWord[g][DW+2*AW +: CW];
    end

    assign drop_err = dropErr_q;
    assign busy     = !(&emptyVec) || lockVld_q;

endmodule

// File: doc/umi_demux_buf.md
# umi_demux_buf

Buffered, transaction-aware 1-to-M UMI demultiplexer for the SUMI fabric. It is the registered successor to the combinational demux. The output channel is decoded directly from a dstaddr bit field, so no external select vector is needed. Each output has its own DEPTH-entry FIFO, so a stalled output does not block traffic bound for the others. Multi-word transactions are held on one output until their end-of-message word. The block sits between a host-side UMI port and M downstream devices or switch ports.

## Interface
Parameters:
- M, 4, number of output channels (2..16, need not be a power of 2)
- DW, 256, UMI data width
- CW, 32, UMI command width
- AW, 64, UMI address width
- SEL_LSB, 40, LSB of the dstaddr field that selects the channel; field width SW = $clog2(M)
- DEPTH, 2, per-output FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- umi_in_valid / umi_in_cmd / umi_in_dstaddr / umi_in_srcaddr / umi_in_data  in  1/CW/AW/AW/DW  input UMI request
- umi_in_ready  out  1  input accepted
- umi_out_valid  out  M  per-channel valid
- umi_out_cmd / umi_out_dstaddr / umi_out_srcaddr / umi_out_data  out  M*CW/M*AW/M*AW/M*DW  packed per-channel fields; channel i occupies slice [i*W +: W]
- umi_out_ready  in  M  per-channel ready
- drop_err  out  1  sticky flag: a word decoded to a channel index ≥ M
- busy  out  1  some FIFO is non-empty or a lock is held

## Operation
- Decode: idx = umi_in_dstaddr[SEL_LSB +: SW].
- Lock: a lock register (lock_vld, lock_idx) holds the channel of an open transaction. While lock_vld = 1, the target is lock_idx and dstaddr is ignored.
- EOM: the end-of-message bit is umi_in_cmd[22].
- Lock transitions on an accepted word:
  - If EOM = 0 and lock_vld = 0: lock_vld <= 1, lock_idx <= target.
  - If EOM = 1: lock_vld <= 0.
- Out-of-range decode (unlocked, idx ≥ M): umi_in_ready = 1, the word is consumed and discarded, drop_err sets, and no lock is taken. drop_err clears only on reset.
- Accept condition: umi_in_valid & umi_in_ready. umi_in_ready = !full[target] (or 1 for a drop).
  - ready depends on the target FIFO only; it does not depend on umi_in_valid in a way that creates loops.
  - ready has no combinational path from umi_out_ready.
- FIFO i: push on accept to i; pop on umi_out_valid[i] & umi_out_ready[i]. A simultaneous push and pop is legal whenever not full.
- Pointers: wr/rd pointers are $clog2(DEPTH)+1 bits with natural wrap. full = MSBs differ and LSBs equal; empty = pointers equal.
- Outputs: umi_out_valid[i] = !empty[i]. Fields come from the head entry and hold stable while valid & !ready.
- Channels are independent: backpressure on channel j never affects acceptance to channel k ≠ j.

## Timing
- Reset values: umi_out_valid = 0, umi_in_ready = !full = 1 (combinational), drop_err = 0, busy = 0, lock_vld = 0, all pointers 0. Data outputs are don't-care when valid = 0 (storage is not reset).
- Latency: a word accepted at edge N is visible on umi_out_valid at N+1 (storage is a register array, not a bypass).
- Throughput: 1 word/cycle per channel with DEPTH ≥ 2 and ready held high.
- Full FIFO: umi_in_ready = 0 toward that channel even if a pop happens in the same cycle. A slot freed at edge N allows accept at N+1.
- Reset mid-transaction: FIFO contents and the lock are discarded. Upstream must reissue.
- Valid/ready rules: valid is never dropped without a handshake. The input side obeys standard UMI rules, and the block tolerates valid that depends on ready.

## Structure
- Shared package umi_pkg: UMI_EOM_BIT = 22 and a umi_req_t struct {cmd, dstaddr, srcaddr, data}, parametrised via localparam widths.
- One sub-module, umi_demux_fifo: a single-channel DEPTH×(CW+2AW+DW) FIFO with push/full/pop/empty, instantiated M times in a generate loop.
- Top level holds the decode, lock register, drop_err, and ready muxing.

## Test plan
- Single-word routing: M=4; send one EOM=1 word each with dstaddr[41:40] = 0..3 → each appears only on its channel, one cycle after accept, fields bit-exact.
- Lock: 3-word transaction (EOM = 0,0,1) with first dstaddr[41:40] = 2 and later words addressed to 0 → all three words exit channel 2; the next EOM=1 word to 0 exits channel 0.
- Isolation: umi_out_ready[1] = 0, DEPTH=2; send 3 words to channel 1, then 1 word to channel 3.
  - umi_in_ready drops on the third channel-1 word.
  - The channel-3 word is not reached until that word drains, because ordering is preserved at the input.
  - After raising ready[1], all 4 words are delivered.
- Out-of-range: M=3, word with idx 3 → accepted, no umi_out_valid, drop_err = 1 and stays 1.
- Reset mid-transaction: assert nreset low after the first word of an open transaction → next cycle valid = 0, busy = 0, lock cleared; a fresh EOM=1 word to channel 1 routes by its own address.
- Random stress: random valid/ready modes 0–2, 10k words; a scoreboard checks per-channel order, no loss or duplication, and lock adherence.
